// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADC  = 4'h1,
    OP_SUB  = 4'h2,
    OP_SBC  = 4'h3,
    OP_RSB  = 4'h4,
    OP_RSC  = 4'h5,
    OP_AND  = 4'h6,
    OP_ORR  = 4'h7,
    OP_EOR  = 4'h8,
    OP_BIC  = 4'h9,
    OP_MOV  = 4'hA,
    OP_MVN  = 4'hB,
    OP_UMUL = 4'hC,
    OP_SMUL = 4'hD,
    OP_UDIV = 4'hE,
    OP_RSV  = 4'hF
  } alu_op_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } alu_state_e;

  function automatic logic is_mul(alu_op_e op);
    return (op == OP_UMUL) || (op == OP_SMUL);
  endfunction

endpackage

// File: rtl/alu_mcycle_if.sv
// Start/busy/done bundle between the control unit and the ALU.
// Handshake: a request is taken on any rising edge where Start=1 and Busy=0; Done pulses for one cycle when Result/Result_Hi/ALUFlags become valid, and those outputs then hold until the next completion.
interface alu_mcycle_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] Src_A;
  logic [WIDTH-1:0] Src_B;
  logic             C_Flag;
  logic             Shifter_carryOut;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result_Hi;
  logic [3:0]       ALUFlags;
  alu_state_e       dbg_state;

  modport master (
    output Start, Op, Src_A, Src_B, C_Flag, Shifter_carryOut,
    input  Busy, Done, Result, Result_Hi, ALUFlags, dbg_state
  );

  modport slave (
    input  Start, Op, Src_A, Src_B, C_Flag, Shifter_carryOut,
    output Busy, Done, Result, Result_Hi, ALUFlags, dbg_state
  );

endinterface

// File: rtl/alu_mcycle_iter.sv
// Iterative datapath: shift-add multiply and restoring divide sharing one hi/lo register pair.
module alu_mcycle_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] fin_lo,
  output logic [WIDTH-1:0] fin_hi
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, mcand;
  logic               neg, div_mode;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, trial, add_sum;
  logic               fits;
  logic [2*WIDTH-1:0] prod;

  // For divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  always_comb begin
    a_mag   = (op == OP_SMUL && a[WIDTH-1]) ? -a : a;
    b_mag   = (op == OP_SMUL && b[WIDTH-1]) ? -b : b;
    shifted = {hi, lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, mcand});
    trial   = shifted - {1'b0, mcand};
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod    = neg ? -{hi, lo} : {hi, lo};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      neg      <= 1'b0;
      div_mode <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      hi       <= '0;
      div_mode <= (op == OP_UDIV);
      neg      <= (op == OP_SMUL) && (a[WIDTH-1] ^ b[WIDTH-1]);
      lo       <= (op == OP_UDIV) ? a : b_mag;
      mcand    <= (op == OP_UDIV) ? b : a_mag;
    end else if (step) begin
      cnt <= cnt + CW'(1);
      if (div_mode) begin
        hi <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], fits};
      end else begin
        {hi, lo} <= {add_sum, lo[WIDTH-1:1]};
      end
    end
  end

  assign last   = (cnt == LAST_CNT);
  assign fin_lo = prod[WIDTH-1:0];
  assign fin_hi = prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mcycle.sv
// Registered ALU: single-cycle arithmetic/logic one edge after acceptance, multiply/divide
// through the iterative sub-block with Busy held until the Done edge.
module alu_mcycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         CLK,
  input logic         RESETn,
  alu_mcycle_if.slave bus
);

  alu_state_e       state, state_next;
  alu_op_e          op_in, op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q, sc_q;
  logic             pend, pend_next;
  logic             done_q, done_next;
  logic [WIDTH-1:0] res_q, hi_q, res_next, hi_next;
  logic [3:0]       flags_q, flags_next;
  logic             busy, accept, start_multi;
  logic             iter_load, iter_step, iter_last;
  logic [WIDTH-1:0] fin_lo, fin_hi;
  logic [WIDTH-1:0] a_e, b_e, logic_res, sc_res, sc_hi;
  logic             cin, arith;
  logic [WIDTH:0]   sum;
  logic [3:0]       sc_flags, mc_flags;

  assign op_in       = alu_op_e'(bus.Op);
  assign busy        = (state != IDLE);
  assign accept      = bus.Start && !busy;
  assign start_multi = is_mul(op_in) || (op_in == OP_UDIV && bus.Src_B != '0);

  // Single-cycle path works on the operands latched at acceptance; pend marks one is waiting.
  always_comb begin
    a_e       = a_q;
    b_e       = b_q;
    cin       = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (op_q)
      OP_ADD:  cin = 1'b0;
      OP_ADC:  cin = c_q;
      OP_SUB:  begin b_e = ~b_q; cin = 1'b1; end
      OP_SBC:  begin b_e = ~b_q; cin = c_q;  end
      OP_RSB:  begin a_e = ~a_q; cin = 1'b1; end
      OP_RSC:  begin a_e = ~a_q; cin = c_q;  end
      default: arith = 1'b0;
    endcase
    sum = {1'b0, a_e} + {1'b0, b_e} + {{WIDTH{1'b0}}, cin};
    case (op_q)
      OP_AND:  logic_res = a_q & b_q;
      OP_ORR:  logic_res = a_q | b_q;
      OP_EOR:  logic_res = a_q ^ b_q;
      OP_BIC:  logic_res = a_q & ~b_q;
      OP_MOV:  logic_res = b_q;
      OP_MVN:  logic_res = ~b_q;
      default: logic_res = '0;
    endcase
    sc_hi    = '0;
    sc_flags = '0;
    if (arith) begin
      sc_res          = sum[WIDTH-1:0];
      sc_flags[C_IDX] = sum[WIDTH];
      sc_flags[V_IDX] = (a_e[WIDTH-1] == b_e[WIDTH-1]) && (sum[WIDTH-1] != a_e[WIDTH-1]);
    end else if (op_q == OP_UDIV) begin
      // Only a zero divisor reaches the single-cycle path.
      sc_res          = '1;
      sc_hi           = a_q;
      sc_flags[C_IDX] = c_q;
      sc_flags[V_IDX] = 1'b1;
    end else if (op_q == OP_RSV) begin
      sc_res          = '0;
      sc_flags[C_IDX] = c_q;
    end else begin
      sc_res          = logic_res;
      sc_flags[C_IDX] = sc_q;
    end
    sc_flags[N_IDX] = (op_q == OP_UDIV) ? 1'b0 : sc_res[WIDTH-1];
    sc_flags[Z_IDX] = (sc_res == '0);
  end

  always_comb begin
    mc_flags        = '0;
    mc_flags[C_IDX] = c_q;
    if (op_q == OP_UDIV) begin
      mc_flags[Z_IDX] = (fin_lo == '0);
    end else begin
      mc_flags[N_IDX] = fin_hi[WIDTH-1];
      mc_flags[Z_IDX] = ({fin_hi, fin_lo} == '0);
    end
  end

  always_comb begin
    state_next = state;
    iter_load  = 1'b0;
    iter_step  = 1'b0;
    pend_next  = 1'b0;
    done_next  = 1'b0;
    res_next   = res_q;
    hi_next    = hi_q;
    flags_next = flags_q;
    if (pend) begin
      done_next  = 1'b1;
      res_next   = sc_res;
      hi_next    = sc_hi;
      flags_next = sc_flags;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          if (start_multi) begin
            state_next = ITER;
            iter_load  = 1'b1;
          end else begin
            pend_next = 1'b1;
          end
        end
      end
      ITER: begin
        iter_step = 1'b1;
        if (iter_last) state_next = FIN;
      end
      FIN: begin
        state_next = IDLE;
        done_next  = 1'b1;
        res_next   = fin_lo;
        hi_next    = fin_hi;
        flags_next = mc_flags;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      pend    <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sc_q    <= 1'b0;
    end else begin
      pend    <= pend_next;
      done_q  <= done_next;
      res_q   <= res_next;
      hi_q    <= hi_next;
      flags_q <= flags_next;
      if (accept) begin
        op_q <= op_in;
        a_q  <= bus.Src_A;
        b_q  <= bus.Src_B;
        c_q  <= bus.C_Flag;
        sc_q <= bus.Shifter_carryOut;
      end
    end
  end

  alu_mcycle_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (CLK),
    .rst_n  (RESETn),
    .load   (iter_load),
    .step   (iter_step),
    .op     (op_in),
    .a      (bus.Src_A),
    .b      (bus.Src_B),
    .last   (iter_last),
    .fin_lo (fin_lo),
    .fin_hi (fin_hi)
  );

  assign bus.Busy      = busy;
  assign bus.Done      = done_q;
  assign bus.Result    = res_q;
  assign bus.Result_Hi = hi_q;
  assign bus.ALUFlags  = flags_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_mcycle.sv
// Directed-vector bench for alu_mcycle (WIDTH=32) with an arithmetic reference model and scoreboard.
module tb_alu_mcycle;

  localparam int W = 32;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  fl;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          c;
    bit          sc;
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  fl;
  } vec_t;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  alu_mcycle_if #(.WIDTH(W)) bus ();
  alu_mcycle #(.WIDTH(W)) dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   b_lo = 1;
  int   b_hi = 0;
  exp_t exp_q[$];
  exp_t held = '{0, 32'h0, 32'h0, 4'h0};
  vec_t vecs[24];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  function automatic bit m_busy(input int c);
    return (c >= b_lo) && (c <= b_hi);
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
    return (op == 4'hC || op == 4'hD || (op == 4'hE && b != 0)) ? W + 1 : 1;
  endfunction

  // Reference: plain integer arithmetic following the op table.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit c, input bit sc);
    exp_t        e;
    logic [31:0] ae, be;
    bit          ci;
    logic [32:0] u;
    longint      ss, sa, sb;
    logic [63:0] p;
    e = '{0, 32'h0, 32'h0, 4'h0};
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        ae = (op == 4'h4 || op == 4'h5) ? ~a : a;
        be = (op == 4'h2 || op == 4'h3) ? ~b : b;
        ci = (op == 4'h0) ? 1'b0 : (op == 4'h2 || op == 4'h4) ? 1'b1 : c;
        u  = {1'b0, ae} + {1'b0, be} + {32'h0, ci};
        ss = longint'($signed(ae)) + longint'($signed(be)) + longint'(ci);
        e.res = u[31:0];
        e.fl  = {u[31], u[31:0] == 0, u[32], (ss > 64'sd2147483647) || (ss < -64'sd2147483648)};
      end
      4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
        case (op)
          4'h6:    e.res = a & b;
          4'h7:    e.res = a | b;
          4'h8:    e.res = a ^ b;
          4'h9:    e.res = a & ~b;
          4'hA:    e.res = b;
          default: e.res = ~b;
        endcase
        e.fl = {e.res[31], e.res == 0, sc, 1'b0};
      end
      4'hC, 4'hD: begin
        if (op == 4'hC) begin
          p = {32'h0, a} * {32'h0, b};
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          p  = sa * sb;
        end
        e.res = p[31:0];
        e.hi  = p[63:32];
        e.fl  = {p[63], p == 0, c, 1'b0};
      end
      4'hE: begin
        if (b == 0) begin
          e.res = 32'hFFFFFFFF;
          e.hi  = a;
          e.fl  = {1'b0, 1'b0, c, 1'b1};
        end else begin
          e.res = a / b;
          e.hi  = a % b;
          e.fl  = {1'b0, e.res == 0, c, 1'b0};
        end
      end
      default: e.fl = {1'b0, 1'b1, c, 1'b0};
    endcase
    return e;
  endfunction

  // One clock: drive inputs, take the edge, advance the model, return at the falling edge.
  task automatic step(input bit st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit c, input bit sc, input bit rn);
    exp_t e;
    int   pre;
    bus.Start = st; bus.Op = op; bus.Src_A = a; bus.Src_B = b;
    bus.C_Flag = c; bus.Shifter_carryOut = sc; RESETn = rn;
    @(posedge CLK);
    pre = cyc;
    cyc = cyc + 1;
    if (!rn) begin
      exp_q.delete();
      held = '{0, 32'h0, 32'h0, 4'h0};
      b_lo = 1;
      b_hi = 0;
    end else if (st && !m_busy(pre)) begin
      e     = model(op, a, b, c, sc);
      e.due = cyc + lat_of(op, b);
      exp_q.push_back(e);
      if (lat_of(op, b) > 1) begin
        b_lo = cyc;
        b_hi = cyc + W;
      end
    end
    @(negedge CLK);
  endtask

  task automatic run_vec(input int i);
    step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sc, 1'b1);
  endtask

  always @(negedge CLK) begin
    bit ed;
    if (cyc >= 1) begin
      ed = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("busy", bus.Busy, m_busy(cyc));
      chk("done", bus.Done, ed);
      if (ed) held = exp_q.pop_front();
      chk("result", bus.Result, held.res);
      chk("result_hi", bus.Result_Hi, held.hi);
      chk("flags", bus.ALUFlags, held.fl);
    end
  end

  initial begin
    exp_t e;
    int   j;
    vecs[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 32'h0, 4'b1001};
    vecs[1]  = '{4'h3, 32'h5, 32'h5, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 4'b1000};
    vecs[2]  = '{4'h5, 32'h3, 32'hA, 1'b1, 1'b0, 32'h7, 32'h0, 4'b0010};
    vecs[3]  = '{4'hE, 32'h1234, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h1234, 4'b0011};
    vecs[4]  = '{4'h6, 32'hF0F0, 32'hFF00, 1'b0, 1'b1, 32'hF000, 32'h0, 4'b0010};
    vecs[5]  = '{4'hB, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 4'b1000};
    vecs[6]  = '{4'h2, 32'h5, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0110};
    vecs[7]  = '{4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0110};
    vecs[8]  = '{4'h8, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100};
    vecs[9]  = '{4'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0110};
    vecs[10] = '{4'h4, 32'h0, 32'h5, 1'b0, 1'b0, 32'h5, 32'h0, 4'b0010};
    vecs[11] = '{4'h7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100};
    vecs[12] = '{4'h3, 32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h0, 4'b0011};
    vecs[13] = '{4'h9, 32'hFFFF00FF, 32'h0F0F0F0F, 1'b0, 1'b0, 32'hF0F000F0, 32'h0, 4'b1000};
    vecs[14] = '{4'hA, 32'h0, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 32'h0, 4'b0010};
    vecs[15] = '{4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h1, 32'hFFFFFFFE, 4'b1000};
    vecs[16] = '{4'hD, 32'hFFFFFFFD, 32'h7, 1'b1, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1010};
    vecs[17] = '{4'hE, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 4'b0000};
    vecs[18] = '{4'hD, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000, 32'h0, 4'b0000};
    vecs[19] = '{4'hE, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 4'b0010};
    vecs[20] = '{4'hC, 32'h0, 32'h12345, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100};
    vecs[21] = '{4'hD, 32'h5, 32'hFFFFFFFE, 1'b0, 1'b0, 32'hFFFFFFF6, 32'hFFFFFFFF, 4'b1000};
    vecs[22] = '{4'hE, 32'd7, 32'd100, 1'b0, 1'b0, 32'h0, 32'd7, 4'b0100};
    vecs[23] = '{4'h0, 32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 32'h0, 4'b0000};

    // Pin the reference model against the hand-computed table.
    for (int i = 0; i < 24; i++) begin
      e = model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sc);
      chk($sformatf("model_res[%0d]", i), e.res, vecs[i].res);
      chk($sformatf("model_hi[%0d]", i), e.hi, vecs[i].hi);
      chk($sformatf("model_fl[%0d]", i), e.fl, vecs[i].fl);
    end
    chk("model_lat_umul", lat_of(4'hC, 32'h1), 33);
    chk("model_lat_div0", lat_of(4'hE, 32'h0), 1);

    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Back-to-back single-cycle ops, one per clock.
    for (int i = 0; i < 15; i++) run_vec(i);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Multi-cycle ops; inputs churn and a stray Start arrives while busy; next op issued in the Done cycle.
    for (int i = 15; i < 23; i++) begin
      run_vec(i);
      j = 0;
      while (m_busy(cyc) && j < 40) begin
        step(j == 3, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1);
        j++;
      end
    end

    j = 0;
    while (exp_q.size() > 0 && j < 50) begin
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      j++;
    end

    // Abort a multiply: stray ADD at cycle 5, reset at cycle 10, then ADD 2+2.
    step(1'b1, 4'hC, 32'hDEADBEEF, 32'h1234, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 10; k++) step(k == 5, 4'h0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    run_vec(23);

    j = 0;
    while (exp_q.size() > 0 && j < 50) begin
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      j++;
    end
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("drain_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mcycle.md
# alu_mcycle

Registered, parametrised-width ALU with a start/busy/done handshake. It executes all ARM data-processing arithmetic and logic ops in one cycle. It also executes unsigned and signed multiply (2·WIDTH-bit product) and unsigned divide iteratively over WIDTH cycles. It sits in the Execute stage beside the shifter, and the control unit stalls the pipeline while Busy is high.

## Interface
- WIDTH, 32, datapath width; legal values are 8 or more.
- CLK  in  1  clock; all state updates on the rising edge.
- RESETn  in  1  synchronous, active-low reset.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  4  operation code: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 RSB, 5 RSC, 6 AND, 7 ORR, 8 EOR, 9 BIC, A MOV, B MVN, C UMUL, D SMUL, E UDIV, F reserved.
- Src_A, Src_B  in  WIDTH  operands.
- C_Flag  in  1  current carry flag.
- Shifter_carryOut  in  1  shifter carry, used for logical ops.
- Busy  out  1  multi-cycle op in progress.
- Done  out  1  one-cycle pulse; results are valid in this cycle.
- Result  out  WIDTH  result, product low word, or quotient.
- Result_Hi  out  WIDTH  product high word or remainder; 0 for single-cycle ops.
- ALUFlags  out  4  {N,Z,C,V}.

## Operation
- Op, Src_A, Src_B and C_Flag are latched when Start is accepted. Later changes to these inputs are ignored.
- Arithmetic is computed as a (WIDTH+1)-bit sum of A', B' and cin:
  - ADD: A+B+0.
  - ADC: A+B+C_Flag.
  - SUB: A+~B+1.
  - SBC: A+~B+C_Flag.
  - RSB: ~A+B+1.
  - RSC: ~A+B+C_Flag.
- Flags for arithmetic ops:
  - C = bit WIDTH of the sum.
  - V = signed overflow of the effective operands.
  - N = Result[WIDTH-1].
  - Z = (Result==0).
- Logical ops (AND, ORR, EOR, BIC, MOV, MVN): C = Shifter_carryOut, V=0, N and Z taken from Result.
- UMUL: shift-add over WIDTH iterations into a 2·WIDTH accumulator.
- SMUL: operand magnitudes are multiplied unsigned. The product is negated in the final cycle if the operand signs differ.
- MUL flags: N = Result_Hi[WIDTH-1], Z = (full product==0), C = C_Flag (preserved), V=0.
- UDIV: restoring division, one quotient bit per iteration, MSB first. Flags: N=0, Z = (quotient==0), C = C_Flag, V=0.
- UDIV by zero is detected at Start and completes as a single-cycle op. Result is all ones, Result_Hi = Src_A, V=1.
- Reserved Op: single-cycle. Result=0, Result_Hi=0, flags {0,1,C_Flag,0}.
- State machine:
  - IDLE→ITER on accepted UMUL, SMUL, or UDIV with a nonzero divisor.
  - IDLE→IDLE, with Done pulsed, on any other accepted op.
  - ITER→FIN when the iteration counter reaches WIDTH-1.
  - FIN→IDLE unconditionally; Done is pulsed on this transition.
- Result, Result_Hi and ALUFlags hold their values after Done until the next accepted Start completes.

## Timing
- Reset value of every output is 0: Busy, Done, Result, Result_Hi, ALUFlags. The state machine resets to IDLE and the counter to 0.
- Single-cycle op: Start is accepted at edge k, and Done plus results are registered at edge k+1. Latency is 1.
- Multi-cycle op: Start is accepted at edge k. Busy=1 from edge k through edge k+WIDTH+1, and Done=1 with results at edge k+WIDTH+1. Latency is WIDTH+1, and Busy drops together with the Done edge.
- Start while Busy=1 is ignored; no queueing.
- Start in the same cycle Done is high is accepted. Back-to-back single-cycle ops give one result per cycle.
- RESETn low at any edge, including mid-iteration, aborts the op. All outputs return to 0 at that edge and the partial result is discarded.
- The counter is ceil(log2(WIDTH))+1 bits wide and never wraps inside an op.

## Structure
- Package alu_pkg holds:
  - the op enum (4-bit);
  - flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0;
  - the state enum {IDLE, ITER, FIN}.
- Sub-module alu_mcycle_iter contains the iterative datapath: accumulator/remainder registers, counter, shift-add and trial-subtract logic, and final negation. It is parametrised by WIDTH.
- The single-cycle adder and logic stay in the top level.

## Test plan
All scenarios use WIDTH=32.
- ADD with 0x7FFFFFFF, 0x00000001: Result=0x80000000, NZCV=1001, Done one edge after Start.
- SBC with 5, 5, C_Flag=0: Result=0xFFFFFFFF, NZCV=1000. RSC with A=3, B=10, C_Flag=1: Result=7, NZCV=0010.
- UMUL with 0xFFFFFFFF, 0xFFFFFFFF: Hi=0xFFFFFFFE, Lo=0x00000001. Busy high for 33 cycles and Done at edge k+33.
- SMUL with -3, 7: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, N=1. UDIV with 100, 7: Result=14, Hi=2.
- UDIV with 0x1234, 0: Result=0xFFFFFFFF, Hi=0x1234, V=1, Done at edge k+1.
- Mid-op disturbances:
  - Start an UMUL, then pulse Start with Op=ADD at cycle 5: the ADD is ignored.
  - RESETn=0 at cycle 10: all outputs are 0 at the next edge, and a subsequent ADD 2+2 yields 4.
